dataram_arbiter: RTL and testbench
==================================

DATARAM_ARBITER -- requirements
Module: dataram_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 8, the number of consecutive denied external-request cycles before the starvation guard fires (range 1-255).
REQ-002 The block SHALL have port CLOCK  in  1  system clock, all state updates on its rising edge.
REQ-003 The block SHALL have port RST_n  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports core_rd / core_wr  in  1 each  core MEM-stage read/write enables.
REQ-005 The block SHALL have ports core_addr / core_wdata  in  32 each  core MEM-stage address and store data.
REQ-006 The block SHALL have port core_rdata  out  32  load data returned to the core WB stage.
REQ-007 The block SHALL have port core_stall  out  1  core MEM access not granted this cycle; the pipeline holds.
REQ-008 The block SHALL have ports ext_req / ext_we  in  1 each  external (loader/debug) request and write qualifier.
REQ-009 The block SHALL have ports ext_addr / ext_wdata  in  32 each  external address and write data.
REQ-010 The block SHALL have port ext_gnt  out  1  external request accepted this cycle.
REQ-011 The block SHALL have ports ext_rvalid  out  1 and ext_rdata  out  32  external read-data return.
REQ-012 The block SHALL have ports ram_ena_rd / ram_ena_wr  out  1 each, ram_addr / ram_wdata  out  32 each, and ram_rdata  in  32, forming a single-port data RAM with 1-cycle read latency.

Function
REQ-013 The block SHALL implement FSM states IDLE (no access), CORE (core owns the RAM this cycle) and EXT (external requester owns the RAM this cycle).
REQ-014 The next state SHALL be chosen every cycle: EXT if the guard fires; else CORE if core_rd|core_wr; else EXT if ext_req; else IDLE.
REQ-015 The RAM port mux SHALL be combinational from the current-cycle grant: core signals when CORE, ext signals when EXT, all ram_* outputs 0 when IDLE.
REQ-016 core_stall SHALL equal (core_rd|core_wr) & ~core_granted, combinationally.
REQ-017 ext_gnt SHALL be high exactly in cycles where the external requester owns the RAM.
REQ-018 The requester SHALL hold ext_req, ext_we, ext_addr and ext_wdata stable until ext_gnt is sampled high, and the block SHALL perform each held request exactly once.
REQ-019 When core_rd and core_wr are both high, the block SHALL perform the write only (ram_ena_rd=0).
REQ-020 A 1-bit rd_owner register SHALL record the owner of each granted read.
REQ-021 ext_rvalid SHALL pulse for 1 cycle, the cycle after an ext read grant, with ext_rdata=ram_rdata in that cycle.
REQ-022 core_rdata SHALL equal ram_rdata in the cycle after a core read grant, and 0 otherwise.
REQ-023 Back-to-back reads by alternating owners SHALL return each datum to its own owner with no loss.
REQ-024 Ext write grants SHALL produce no ext_rvalid.

Reset
REQ-025 While RST_n=0 the state SHALL be IDLE, rd_owner and the read-pending flag 0, starve_cnt 0, and ext_gnt, ext_rvalid and all ram_* outputs 0.
REQ-026 A read pending when reset asserts SHALL be discarded, with no rvalid after release.
REQ-027 The first arbitration after reset release SHALL occur on the first rising CLOCK edge with RST_n=1.

Configuration
REQ-028 With ARB_STARVE_GUARD_EN defined, an 8-bit starve_cnt SHALL increment each cycle ext_req=1 and ext_gnt=0, and clear on ext_gnt or ext_req=0.
REQ-029 With ARB_STARVE_GUARD_EN defined, when starve_cnt==STARVE_MAX the next cycle SHALL grant EXT regardless of core requests (core_stall=1 if the core requests).
REQ-030 Without ARB_STARVE_GUARD_EN, arbitration SHALL be strict core priority, starve_cnt SHALL not exist, STARVE_MAX SHALL be unused, and external starvation is permitted.

Verification
REQ-031 The bench SHALL cover: core_rd addr 0x10, RAM[0x10]=0xDEADBEEF -> ram_ena_rd=1 that cycle, core_rdata=0xDEADBEEF next cycle, core_stall=0.
REQ-032 The bench SHALL cover: ext_req write addr 0x20 data 0x1234 with core idle -> ext_gnt=1 same cycle, ram_ena_wr=1, ram_wdata=0x1234, no ext_rvalid.
REQ-033 The bench SHALL cover: core_rd and ext_req read in the same cycle -> core granted, ext_gnt=0; next cycle with core idle ext_gnt=1; ext_rvalid the following cycle with correct data.
REQ-034 The bench SHALL cover: with guard enabled and STARVE_MAX=4, core requesting continuously and ext_req held -> ext_gnt in cycle 6 with core_stall=1 that cycle only; without the macro ext_gnt never asserts.
REQ-035 The bench SHALL cover: core_rd and core_wr both high -> ram_ena_wr=1, ram_ena_rd=0, core_rdata=0 next cycle.
REQ-036 The bench SHALL cover: ext read granted then RST_n pulled low before the next edge -> after release ext_rvalid=0, state IDLE, all outputs 0.

Source files
------------

// File: rtl/dataram_arbiter.sv
// Single-port data RAM arbiter between the core MEM stage and an external loader/debug port.
// Optional starvation guard for the external port is enabled by defining ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no RAM access this cycle
// CORE  | core owns the RAM this cycle
// EXT   | external requester owns the RAM this cycle
module dataram_arbiter #(
  parameter int STARVE_MAX = 8
) (
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        core_rd,
  input  logic        core_wr,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        ram_ena_rd,
  output logic        ram_ena_wr,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, CORE, EXT} state_t;

  state_t state;
  logic   core_req;
  logic   guard_fire;
  logic   rd_pend;
  logic   rd_owner;

  assign core_req = core_rd | core_wr;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_cnt;
  logic       guard_q;

  // guard_q arms one cycle after the count reaches the limit while still denied
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      starve_cnt <= 8'd0;
      guard_q    <= 1'b0;
    end else begin
      if (ext_req && !ext_gnt) begin
        if (starve_cnt != 8'hFF)
          starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= 8'd0;
      end
      guard_q <= ext_req && !ext_gnt && (starve_cnt == STARVE_LIM);
    end
  end

  assign guard_fire = guard_q & ext_req;
`else
  assign guard_fire = 1'b0;
`endif

  // Ownership is decided from this cycle's requests so a grant never costs a bubble
  always_comb begin
    state = IDLE;
    if (!RST_n)
      state = IDLE;
    else if (guard_fire)
      state = EXT;
    else if (core_req)
      state = CORE;
    else if (ext_req)
      state = EXT;
  end

  always_comb begin
    ram_ena_rd = 1'b0;
    ram_ena_wr = 1'b0;
    ram_addr   = 32'd0;
    ram_wdata  = 32'd0;
    case (state)
      CORE: begin
        ram_ena_rd = core_rd & ~core_wr;
        ram_ena_wr = core_wr;
        ram_addr   = core_addr;
        ram_wdata  = core_wdata;
      end
      EXT: begin
        ram_ena_rd = ~ext_we;
        ram_ena_wr = ext_we;
        ram_addr   = ext_addr;
        ram_wdata  = ext_wdata;
      end
      default: ;
    endcase
  end

  assign core_stall = core_req & (state != CORE);
  assign ext_gnt    = (state == EXT);

  // Reset drops any in-flight read so no stale rvalid appears after release
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= ram_ena_rd;
      if (ram_ena_rd)
        rd_owner <= (state == EXT);
    end
  end

  assign ext_rvalid = rd_pend & rd_owner;
  assign ext_rdata  = ext_rvalid ? ram_rdata : 32'd0;
  assign core_rdata = (rd_pend && !rd_owner) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dataram_arbiter.sv
// Directed bench for dataram_arbiter with a behavioural RAM and per-cycle reference model.
module tb_dataram_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int SMAX = 4;

  logic        CLOCK = 1'b0;
  logic        RST_n = 1'b0;
  logic        core_rd = 1'b0, core_wr = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [31:0] ext_addr = '0, ext_wdata = '0;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        ram_ena_rd, ram_ena_wr;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;
  int tag = 0;

  dataram_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLOCK(CLOCK), .RST_n(RST_n),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_ena_rd(ram_ena_rd), .ram_ena_wr(ram_ena_wr), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 CLOCK = ~CLOCK;

  // Behavioural single-port RAM, 1-cycle read latency
  logic [31:0] mem [0:255];
  bit mem_loaded = 1'b0;
  always @(posedge CLOCK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 16) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
      mem_loaded <= 1'b1;
    end else begin
      if (ram_ena_rd) ram_rdata <= mem[ram_addr[7:0]];
      if (ram_ena_wr) mem[ram_addr[7:0]] <= ram_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner of each cycle and what returns the cycle after a read
  bit          m_pend = 0, m_ext = 0;
  logic [31:0] m_data = '0;
  int          run = 0;

  always begin : model
    int          owner;
    logic        e_rd, e_wr, e_rv;
    logic [31:0] e_addr, e_wd;
    bit          n_pend, n_ext;
    logic [31:0] n_data;
    int          n_run;
    @(negedge CLOCK);
    if (!RST_n) owner = 0;
    else if (GUARD && ext_req && run > SMAX) owner = 2;
    else if (core_rd || core_wr) owner = 1;
    else if (ext_req) owner = 2;
    else owner = 0;
    e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
    if (owner == 1) begin
      e_rd = core_rd && !core_wr; e_wr = core_wr; e_addr = core_addr; e_wd = core_wdata;
    end else if (owner == 2) begin
      e_rd = !ext_we; e_wr = ext_we; e_addr = ext_addr; e_wd = ext_wdata;
    end
    e_rv = m_pend && m_ext;
    chk("ram_ena_rd", 32'(ram_ena_rd), 32'(e_rd));
    chk("ram_ena_wr", 32'(ram_ena_wr), 32'(e_wr));
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_wdata", ram_wdata, e_wd);
    chk("ext_gnt", 32'(ext_gnt), 32'(owner == 2));
    chk("core_stall", 32'(core_stall), 32'((core_rd || core_wr) && owner != 1));
    chk("ext_rvalid", 32'(ext_rvalid), 32'(e_rv));
    chk("ext_rdata", ext_rdata, e_rv ? m_data : 32'd0);
    chk("core_rdata", core_rdata, (m_pend && !m_ext) ? m_data : 32'd0);
    case (tag)
      1:  begin chk("t1_rd", 32'(ram_ena_rd), 1); chk("t1_stall", 32'(core_stall), 0); end
      2:  chk("t2_core_rdata", core_rdata, 32'hDEADBEEF);
      3:  begin chk("t3_gnt", 32'(ext_gnt), 1); chk("t3_wr", 32'(ram_ena_wr), 1);
                chk("t3_wdata", ram_wdata, 32'h1234); chk("t3_addr", ram_addr, 32'h20); end
      4:  chk("t4_no_rvalid", 32'(ext_rvalid), 0);
      5:  begin chk("t5_gnt", 32'(ext_gnt), 0); chk("t5_stall", 32'(core_stall), 0); end
      6:  chk("t6_gnt", 32'(ext_gnt), 1);
      7:  begin chk("t7_rvalid", 32'(ext_rvalid), 1); chk("t7_rdata", ext_rdata, 32'hA5000030); end
      8:  begin chk("t8_gnt", 32'(ext_gnt), 0); chk("t8_stall", 32'(core_stall), 0); end
      10: begin chk("t10_gnt", 32'(ext_gnt), 32'(GUARD)); chk("t10_stall", 32'(core_stall), 32'(GUARD)); end
      11: begin chk("t11_rvalid", 32'(ext_rvalid), 1); chk("t11_rdata", ext_rdata, 32'h1234); end
      12: begin chk("t12_wr", 32'(ram_ena_wr), 1); chk("t12_rd", 32'(ram_ena_rd), 0); end
      13: chk("t13_core_rdata", core_rdata, 0);
      14: chk("t14_gnt", 32'(ext_gnt), 1);
      15: begin chk("t15_rvalid", 32'(ext_rvalid), 0); chk("t15_gnt", 32'(ext_gnt), 0);
                chk("t15_addr", ram_addr, 0); chk("t15_rd", 32'(ram_ena_rd), 0); end
      16: begin chk("t16_rst_gnt", 32'(ext_gnt), 0); chk("t16_rst_rd", 32'(ram_ena_rd), 0); end
      17: begin chk("t17_gnt", 32'(ext_gnt), 0); chk("t17_stall", 32'(core_stall), 0); end
      18: chk("t18_gnt", 32'(ext_gnt), 32'(!GUARD));
      default: ;
    endcase
    n_pend = RST_n && e_rd;
    n_ext  = (owner == 2);
    n_data = mem[e_addr[7:0]];
    n_run  = (RST_n && ext_req && owner != 2) ? run + 1 : 0;
    @(posedge CLOCK or negedge RST_n);
    if (!RST_n) begin
      m_pend = 0; m_ext = 0; m_data = '0; run = 0;
    end else begin
      m_pend = n_pend; m_ext = n_ext; m_data = n_data; run = n_run;
    end
  end

  task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                     input int t);
    @(posedge CLOCK); #1;
    core_rd = cr; core_wr = cw; core_addr = ca; core_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    tag = t;
  endtask

  task automatic idle(input int t);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, t);
  endtask

  initial begin
    // reset with an external request present
    cyc(0, 0, 0, 0, 1, 0, 32'h44, 0, 16);
    idle(0);
    @(negedge CLOCK); #2; RST_n = 1'b1;
    idle(0);
    // core read of preloaded word
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
    idle(2);
    // external write, core idle
    cyc(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234, 3);
    idle(4);
    // simultaneous core read and ext read
    cyc(1, 0, 32'h11, 0, 1, 0, 32'h30, 0, 5);
    cyc(0, 0, 0, 0, 1, 0, 32'h30, 0, 6);
    idle(7);
    // alternating owners back to back
    cyc(1, 0, 32'h12, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
    cyc(1, 0, 32'h13, 0, 0, 0, 0, 0, 11);
    idle(0);
    // read+write together performs write only
    cyc(1, 1, 32'h60, 32'hCAFE0001, 0, 0, 0, 0, 12);
    idle(13);
    cyc(1, 0, 32'h60, 0, 0, 0, 0, 0, 0);
    idle(0);
    // starvation: core busy for 10 cycles, ext held until granted
    for (int i = 1; i <= 11; i++) begin
      cyc(i <= 10, 0, 32'h70 + 32'(i), 0, GUARD ? (i <= 6) : 1'b1, 0, 32'h50, 0,
          (i == 6) ? 10 : (i == 7) ? 17 : (i <= 10) ? 8 : 18);
    end
    idle(0);
    idle(0);
    // ext read granted, then reset before its data returns
    cyc(0, 0, 0, 0, 1, 0, 32'h40, 0, 14);
    @(negedge CLOCK); #2;
    RST_n = 1'b0;
    ext_req = 1'b0; tag = 0;
    @(negedge CLOCK); #2;
    RST_n = 1'b1;
    idle(15);
    idle(0);
    idle(0);
    @(posedge CLOCK); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
